// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared encodings for the fetch/load-store memory arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;

    localparam int                    MAX_DATA_W   = 64;
    localparam logic [MAX_DATA_W-1:0] TIMEOUT_DATA = '1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick : combinational I/D grant pick; ARB_ROUND_ROBIN_EN adds the RR pointer
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_fetch_valid,
    input  logic i_lsu_valid,
    input  logic i_idle,
    output logic o_fetch_grant,
    output logic o_lsu_grant
);

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q;
    owner_e last_d;

    always_comb begin
        o_fetch_grant = 1'b0;
        o_lsu_grant   = 1'b0;
        last_d        = last_q;
        if (i_idle) begin
            if (i_fetch_valid && i_lsu_valid) begin
                if (last_q == OWN_I) begin
                    o_lsu_grant = 1'b1;
                end else begin
                    o_fetch_grant = 1'b1;
                end
            end else begin
                o_fetch_grant = i_fetch_valid;
                o_lsu_grant   = i_lsu_valid;
            end
        end
        if (o_fetch_grant) begin
            last_d = OWN_I;
        end else if (o_lsu_grant) begin
            last_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Load/store always wins so the execute stage is never starved by fetch.
    assign o_lsu_grant   = i_idle & i_lsu_valid;
    assign o_fetch_grant = i_idle & i_fetch_valid & ~i_lsu_valid;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory bus between fetch (I) and load/store (D),
//                    one outstanding transaction, with a response watchdog.
//                    Optional macro: ARB_ROUND_ROBIN_EN (else D has fixed priority).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_i,
    output logic              i_ready_o,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_rvalid_ro,
    output logic [DATA_W-1:0] i_rdata_ro,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic              d_write_i,
    input  logic [1:0]        d_width_i,
    output logic              d_rvalid_ro,
    output logic [DATA_W-1:0] d_rdata_ro,
    output logic              mem_req_ro,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_ro,
    output logic [DATA_W-1:0] mem_wdata_ro,
    output logic              mem_we_ro,
    output logic [1:0]        mem_width_ro,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_ro
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                mem_req_q,   mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q,    mem_we_d;
    logic [1:0]          mem_width_q, mem_width_d;
    logic                i_rvalid_q,  i_rvalid_d;
    logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                err_q,       err_d;
    logic [CNT_W-1:0]    wdog_q,      wdog_d;

    logic                i_grant;
    logic                d_grant;
    logic                resp_fire;
    logic [DATA_W-1:0]   resp_data;

    mem_arb_pick u_pick (
        .clk           (clk),
        .rst           (rst),
        .i_fetch_valid (i_valid_i),
        .i_lsu_valid   (d_valid_i),
        .i_idle        (state_q == ST_IDLE),
        .o_fetch_grant (i_grant),
        .o_lsu_grant   (d_grant)
    );

    assign i_ready_o = i_grant;
    assign d_ready_o = d_grant;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_width_d = mem_width_q;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        resp_fire   = 1'b0;
        resp_data   = mem_rdata_i;

        case (state_q)
            ST_IDLE: begin
                if (d_grant) begin
                    owner_d     = OWN_D;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_we_d    = d_write_i;
                    // funct3[1:0]==3 never occurs for a legal access; treat it as a word.
                    mem_width_d = (d_width_i == WIDTH_B || d_width_i == WIDTH_H) ? d_width_i : WIDTH_W;
                end else if (i_grant) begin
                    owner_d     = OWN_I;
                    mem_addr_d  = i_addr_i;
                    mem_wdata_d = '0;
                    mem_we_d    = 1'b0;
                    mem_width_d = WIDTH_W;
                end
                if (d_grant || i_grant) begin
                    mem_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wdog_q != TIMEOUT_CNT) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (mem_rvalid_i) begin
                    resp_fire = 1'b1;
                end else if (wdog_d == TIMEOUT_CNT) begin
                    resp_fire = 1'b1;
                    resp_data = TIMEOUT_DATA[DATA_W-1:0];
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (resp_fire) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = resp_data;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_width_q <= 2'd0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_width_q <= mem_width_d;
            i_rvalid_q  <= i_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign mem_req_ro   = mem_req_q;
    assign mem_addr_ro  = mem_addr_q;
    assign mem_wdata_ro = mem_wdata_q;
    assign mem_we_ro    = mem_we_q;
    assign mem_width_ro = mem_width_q;
    assign i_rvalid_ro  = i_rvalid_q;
    assign i_rdata_ro   = i_rdata_q;
    assign d_rvalid_ro  = d_rvalid_q;
    assign d_rdata_ro   = d_rdata_q;
    assign err_ro       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed table + random traffic against a transaction-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid_i = 1'b0, i_ready_o, i_rvalid_ro;
    logic [31:0] i_addr_i = '0, i_rdata_ro;
    logic        d_valid_i = 1'b0, d_ready_o, d_write_i = 1'b0, d_rvalid_ro;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0, d_rdata_ro;
    logic [1:0]  d_width_i = 2'd0, mem_width_ro;
    logic        mem_req_ro, mem_gnt_i = 1'b0, mem_we_ro, mem_rvalid_i = 1'b0, err_ro;
    logic [31:0] mem_addr_ro, mem_wdata_ro, mem_rdata_i = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
        .i_rvalid_ro(i_rvalid_ro), .i_rdata_ro(i_rdata_ro),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_write_i(d_write_i), .d_width_i(d_width_i),
        .d_rvalid_ro(d_rvalid_ro), .d_rdata_ro(d_rdata_ro),
        .mem_req_ro(mem_req_ro), .mem_gnt_i(mem_gnt_i), .mem_addr_ro(mem_addr_ro),
        .mem_wdata_ro(mem_wdata_ro), .mem_we_ro(mem_we_ro), .mem_width_ro(mem_width_ro),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_ro(err_ro)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          we;
        logic [1:0]  width;
    } txn_t;

    txn_t        m_q[$];
    bit          m_granted, m_last_d, chk_en;
    int          m_waited;
    logic        e_i_rv, e_d_rv, e_err, e_req, e_we, e_d_ok;
    logic [31:0] e_i_rd, e_d_rd, e_addr, e_wdata;
    logic [1:0]  e_width;

    // Which port the arbiter must accept given the current request lines.
    function automatic void exp_ready(output bit ri, output bit rd);
        ri = 1'b0;
        rd = 1'b0;
        if (m_q.size() == 0) begin
            if (i_valid_i && d_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m_last_d) ri = 1'b1; else rd = 1'b1;
`else
                rd = 1'b1;
`endif
            end else begin
                ri = i_valid_i;
                rd = d_valid_i;
            end
        end
    endfunction

    function automatic void deliver(input logic [31:0] v, input bit known);
        if (m_q[0].is_d) begin
            e_d_rv = 1'b1; e_d_rd = v; e_d_ok = known;
        end else begin
            e_i_rv = 1'b1; e_i_rd = v;
        end
        void'(m_q.pop_front());
    endfunction

    always @(posedge clk) begin : p_model
        bit   ri, rd;
        txn_t t;
        exp_ready(ri, rd);
        if (!rst) begin
            m_q.delete();
            m_granted = 0; m_waited = 0; m_last_d = 0;
            e_i_rv = 0; e_d_rv = 0; e_err = 0; e_req = 0; e_we = 0; e_d_ok = 1;
            e_i_rd = 0; e_d_rd = 0; e_addr = 0; e_wdata = 0; e_width = 0;
        end else begin
            e_i_rv = 0;
            e_d_rv = 0;
            if (m_q.size() != 0 && !m_granted) begin
                if (mem_gnt_i) begin m_granted = 1; m_waited = 0; end
            end else if (m_q.size() != 0) begin
                if (mem_rvalid_i) deliver(mem_rdata_i, !(m_q[0].is_d && m_q[0].we));
                else begin
                    m_waited++;
                    if (m_waited >= TO) begin e_err = 1; deliver(32'hFFFF_FFFF, 1'b1); end
                end
            end else if (ri || rd) begin
                t.is_d  = rd;
                t.addr  = rd ? d_addr_i : i_addr_i;
                t.we    = rd ? d_write_i : 1'b0;
                t.width = rd ? d_width_i : 2'd2;
                m_q.push_back(t);
                m_granted = 0;
                m_last_d  = rd;
                e_addr = t.addr; e_we = t.we; e_width = t.width;
                if (rd) e_wdata = d_wdata_i;
            end
            e_req = (m_q.size() != 0) && !m_granted;
        end
    end

    always @(negedge clk) begin : p_check
        bit ri, rd;
        if (chk_en) begin
            exp_ready(ri, rd);
            chk("i_ready", i_ready_o, ri);
            chk("d_ready", d_ready_o, rd);
            chk("mem_req", mem_req_ro, e_req);
            chk("mem_addr", mem_addr_ro, e_addr);
            chk("mem_we", mem_we_ro, e_we);
            chk("mem_width", mem_width_ro, e_width);
            if (e_req && m_q[0].is_d) chk("mem_wdata", mem_wdata_ro, e_wdata);
            chk("i_rvalid", i_rvalid_ro, e_i_rv);
            chk("d_rvalid", d_rvalid_ro, e_d_rv);
            chk("i_rdata", i_rdata_ro, e_i_rd);
            if (e_d_ok) chk("d_rdata", d_rdata_ro, e_d_rd);
            chk("err", err_ro, e_err);
        end
    end

    // ---------------- stimulus ----------------
    bit acc_i, acc_d, auto_mem, auto_req;

    task automatic cycle();
        @(negedge clk);
        acc_i = i_ready_o;
        acc_d = d_ready_o;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_gnt_i    = ($urandom_range(0, 1) == 1);
            mem_rvalid_i = ($urandom_range(0, 2) == 0);
            mem_rdata_i  = $urandom;
        end
        if (auto_req) begin
            if (acc_i) i_valid_i = 1'b0;
            if (acc_d) d_valid_i = 1'b0;
            if (!i_valid_i && $urandom_range(0, 2) == 0) begin
                i_valid_i = 1'b1;
                i_addr_i  = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_valid_i && $urandom_range(0, 2) == 0) begin
                d_valid_i = 1'b1;
                d_addr_i  = $urandom;
                d_wdata_i = $urandom;
                d_write_i = $urandom_range(0, 1);
                d_width_i = 2'($urandom_range(0, 2));
            end
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr, wdata;
        bit          we;
        logic [1:0]  width;
        int          gnt_dly, rv_dly;
        logic [31:0] rdata;
        logic [1:0]  exp_width;
        bit          exp_we;
    } vec_t;

    vec_t tab[6];

    task automatic run_vec(input vec_t v, input string nm);
        if (v.is_d) begin
            d_valid_i = 1'b1; d_addr_i = v.addr; d_wdata_i = v.wdata;
            d_write_i = v.we; d_width_i = v.width;
        end else begin
            i_valid_i = 1'b1; i_addr_i = v.addr;
        end
        cycle();
        chk({nm, "_accept"}, v.is_d ? acc_d : acc_i, 1'b1);
        chk({nm, "_other_ready"}, v.is_d ? acc_i : acc_d, 1'b0);
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        chk({nm, "_mem_addr"}, mem_addr_ro, v.addr);
        chk({nm, "_mem_we"}, mem_we_ro, v.exp_we);
        chk({nm, "_mem_width"}, mem_width_ro, v.exp_width);
        if (v.exp_we) chk({nm, "_mem_wdata"}, mem_wdata_ro, v.wdata);
        for (int k = 0; k < v.gnt_dly; k++) begin
            i_valid_i = 1'b1;
            d_valid_i = 1'b1;
            cycle();
            chk({nm, "_hold_req"}, mem_req_ro, 1'b1);
            chk({nm, "_hold_addr"}, mem_addr_ro, v.addr);
            chk({nm, "_hold_ready"}, {acc_i, acc_d}, 2'b00);
        end
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        chk({nm, "_req_drop"}, mem_req_ro, 1'b0);
        for (int k = 0; k < v.rv_dly; k++) cycle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        cycle();
        mem_rvalid_i = 1'b0;
        chk({nm, "_rvalid"}, v.is_d ? d_rvalid_ro : i_rvalid_ro, 1'b1);
        chk({nm, "_other_rvalid"}, v.is_d ? i_rvalid_ro : d_rvalid_ro, 1'b0);
        if (!v.exp_we) chk({nm, "_rdata"}, v.is_d ? d_rdata_ro : i_rdata_ro, v.rdata);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin : p_main
        int         n;
        logic [7:0] ord;
        logic [7:0] exp_ord;
        int         ni, nd;

        tab[0] = '{0, 32'h100, 32'h0,        0, 2'd0, 0, 0, 32'h0000_0013, 2'd2, 0};
        tab[1] = '{1, 32'h200, 32'hDEADBEEF, 1, 2'd0, 0, 0, 32'h0,         2'd0, 1};
        tab[2] = '{1, 32'h304, 32'h0,        0, 2'd1, 5, 2, 32'h0000_BEEF, 2'd1, 0};
        tab[3] = '{0, 32'h104, 32'h0,        0, 2'd0, 1, 3, 32'h00A0_0093, 2'd2, 0};
        tab[4] = '{1, 32'h400, 32'h55,       0, 2'd2, 0, 0, 32'h1234_5678, 2'd2, 0};
        tab[5] = '{1, 32'h401, 32'hA5,       1, 2'd1, 2, 1, 32'h0,         2'd1, 1};

        do_reset();
        chk("reset_err", err_ro, 1'b0);
        chk("reset_mem_req", mem_req_ro, 1'b0);
        chk("reset_rvalid", {i_rvalid_ro, d_rvalid_ro}, 2'b00);
        chk("reset_rdata", {i_rdata_ro, d_rdata_ro}, 64'h0);
        chk_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tab[i], $sformatf("vec%0d", i));

        // Both ports contend for four requests each.
        do_reset();
        auto_mem = 1'b1;
        ni = 4; nd = 4; ord = '0; n = 0;
        i_valid_i = 1'b1; i_addr_i = 32'h800;
        d_valid_i = 1'b1; d_addr_i = 32'h900; d_write_i = 1'b0; d_width_i = 2'd2;
        while ((ni > 0 || nd > 0) && n < 500) begin
            cycle();
            n++;
            if (acc_d) begin ord = {ord[6:0], 1'b1}; nd--; if (nd == 0) d_valid_i = 1'b0; end
            if (acc_i) begin ord = {ord[6:0], 1'b0}; ni--; if (ni == 0) i_valid_i = 1'b0; end
        end
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        chk("arb_finished", n < 500, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = 8'b1010_1010;
`else
        exp_ord = 8'b1111_0000;
`endif
        chk("arb_order", ord, exp_ord);
        n = 0;
        while (m_q.size() != 0 && n < 200) begin cycle(); n++; end
        auto_mem = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        cycle();

        // Memory never answers: watchdog fires after TO waiting cycles.
        i_valid_i = 1'b1; i_addr_i = 32'h500;
        cycle();
        chk("to_accept", acc_i, 1'b1);
        i_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!i_rvalid_ro && n < 300);
        chk("to_cycles", n, TO);
        chk("to_err", err_ro, 1'b1);
        chk("to_rdata", i_rdata_ro, 32'hFFFF_FFFF);
        run_vec(tab[0], "after_to");
        chk("err_sticky", err_ro, 1'b1);

        // Reset while waiting, followed by a stray memory response.
        d_valid_i = 1'b1; d_addr_i = 32'h600; d_write_i = 1'b0; d_width_i = 2'd2;
        cycle();
        d_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        cycle();
        mem_rvalid_i = 1'b0;
        chk("rst_err", err_ro, 1'b0);
        chk("rst_rvalid", {i_rvalid_ro, d_rvalid_ro}, 2'b00);
        chk("rst_mem", {mem_req_ro, mem_addr_ro}, 33'h0);
        chk("rst_rdata", {i_rdata_ro, d_rdata_ro}, 64'h0);
        cycle();
        chk("rst_late_rvalid", {i_rvalid_ro, d_rvalid_ro}, 2'b00);
        run_vec(tab[4], "after_rst");

        // Random traffic with a randomly stalling memory.
        auto_mem = 1'b1;
        auto_req = 1'b1;
        for (int c = 0; c < 3000; c++) cycle();
        auto_req = 1'b0;
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        n = 0;
        while (m_q.size() != 0 && n < 300) begin cycle(); n++; end
        chk("drain", m_q.size() == 0, 1'b1);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : p_guard
        #1_000_000;
        n_bad++;
        $display("FAIL tb_timeout: got still running, required finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
